cpu6_ifid_fetchbuf: RTL and testbench

- Fetch-to-decode stage of cpu6: a DEPTH-entry FIFO buffer between the instruction-fetch bus interface and the decoder / ID-EX pipeline register.
- Decouples variable-latency fetch returns from decode stalls.
- Presents {pc, instr} in order with a valid flag.
- Supports a pipeline flush ("flash") that drops all buffered and in-flight instructions.

---
 rtl/cpu6_ifid_fetchbuf_if.sv | 32 +++
 rtl/cpu6_ifid_fetchbuf.sv | 94 +++++++++
 tb/tb_cpu6_ifid_fetchbuf.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_ifid_fetchbuf_if.sv
// Fetch-to-decode buffer bus: fetch-return handshake, flush and decode-side head view.
// The fetch/control side uses the master modport; the buffer itself uses the slave modport.
interface cpu6_ifid_fetchbuf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flash;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_fault;
  logic            stallD;
  logic            validD;
  logic [XLEN-1:0] pcD;
  logic [XLEN-1:0] instrD;
  logic            faultD;
  logic            illegalD;
  logic [CW-1:0]   countD;

  modport master (
    output flash, in_valid, in_pc, in_instr, in_fault, stallD,
    input  in_ready, validD, pcD, instrD, faultD, illegalD, countD
  );

  modport slave (
    input  flash, in_valid, in_pc, in_instr, in_fault, stallD,
    output in_ready, validD, pcD, instrD, faultD, illegalD, countD
  );
endinterface

// File: rtl/cpu6_ifid_fetchbuf.sv
// cpu6 fetch-to-decode buffer: DEPTH-entry FIFO of {pc, instr, fault} with flush.
// One-cycle latency, no in-to-out bypass; a bubble (pc=0, instr=NOP) is shown when empty.
// Optional feature: define CPU6_IFID_ILLEGAL_CHK_EN to flag non-32-bit encodings on illegalD.
module cpu6_ifid_fetchbuf #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 2,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu6_ifid_fetchbuf_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic            mem_fault [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  // Handshake decode and next-state for pointers and occupancy
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    full          = (count_q == CW'(DEPTH));
    empty         = (count_q == '0);
    bus.in_ready  = ~full & ~bus.flash;
    push          = bus.in_valid & bus.in_ready;
    pop           = ~empty & ~bus.stallD & ~bus.flash;
    rp_d          = rp_q;
    wp_d          = wp_q;
    count_d       = count_q;
    if (bus.flash) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      if (pop)  rp_d = rp_q + AW'(1);
      if (push) wp_d = wp_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Entry write on push
  always_ff @(posedge clk) begin
    // NOTE: entries are not reset; occupancy gates every read, so their contents are don't-care.
    if (push) begin
      mem_pc[wp_q]    <= bus.in_pc;
      mem_instr[wp_q] <= bus.in_instr;
      mem_fault[wp_q] <= bus.in_fault;
    end
  end

  // Head view: entry at rp when occupied, otherwise a bubble
  always_comb begin
    bus.validD = ~empty;
    bus.countD = count_q;
    bus.pcD    = '0;
    bus.instrD = NOP;
    bus.faultD = 1'b0;
    if (!empty) begin
      bus.pcD    = mem_pc[rp_q];
      bus.instrD = mem_instr[rp_q];
      bus.faultD = mem_fault[rp_q];
    end
  end

`ifdef CPU6_IFID_ILLEGAL_CHK_EN
  // Flag compressed/16-bit encodings at the head; derived, never stored
  assign bus.illegalD = bus.validD & (bus.instrD[1:0] != 2'b11);
`else
  assign bus.illegalD = 1'b0;
`endif
endmodule

// File: tb/tb_cpu6_ifid_fetchbuf.sv
// Self-checking bench for cpu6_ifid_fetchbuf: directed vector table, hand-written
// reset/flush sequences, then random traffic against a queue-based reference model.
module tb_cpu6_ifid_fetchbuf;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef CPU6_IFID_ILLEGAL_CHK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu6_ifid_fetchbuf_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  cpu6_ifid_fetchbuf #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic flt, input logic st);
    bus.flash    = fl;
    bus.in_valid = iv;
    bus.in_pc    = pc;
    bus.in_instr = ins;
    bus.in_fault = flt;
    bus.stallD   = st;
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fl, iv;
    logic [31:0] pc, ins;
    logic        flt, st;
    logic        ev;
    logic [31:0] epc, eins;
    logic        efl, eil;
    int          ecnt;
    logic        erdy;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic fl, input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic flt, input logic st, input logic ev, input logic [31:0] epc,
                     input logic [31:0] eins, input logic efl, input logic eil, input int ecnt,
                     input logic erdy);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.flt = flt; v.st = st;
    v.ev = ev; v.epc = epc; v.eins = eins; v.efl = efl; v.eil = eil; v.ecnt = ecnt; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic add_idle_empty();
    add(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 1);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        flt;
  } ent_t;
  ent_t q[$];

  task automatic check_model(input int cyc);
    logic        ev;
    logic [31:0] epc, eins;
    logic        efl, eil;
    ev   = (q.size() != 0);
    epc  = ev ? q[0].pc  : 32'h0;
    eins = ev ? q[0].ins : NOP;
    efl  = ev ? q[0].flt : 1'b0;
    eil  = ILL_EN & ev & (eins[1:0] != 2'b11);
    check($sformatf("rnd%0d validD", cyc),   64'(bus.validD),   64'(ev));
    check($sformatf("rnd%0d pcD", cyc),      64'(bus.pcD),      64'(epc));
    check($sformatf("rnd%0d instrD", cyc),   64'(bus.instrD),   64'(eins));
    check($sformatf("rnd%0d faultD", cyc),   64'(bus.faultD),   64'(efl));
    check($sformatf("rnd%0d illegalD", cyc), 64'(bus.illegalD), 64'(eil));
    check($sformatf("rnd%0d countD", cyc),   64'(bus.countD),   64'(q.size()));
    check($sformatf("rnd%0d in_ready", cyc), 64'(bus.in_ready),
          64'((q.size() < DEPTH) && !bus.flash));
  endtask

  // Apply one clock edge to the model; returns whether the fetch word was accepted
  task automatic model_edge(output logic accepted);
    ent_t e;
    accepted = 1'b0;
    if (bus.flash) begin
      q.delete();
    end else begin
      accepted = bus.in_valid && (q.size() < DEPTH);
      if (q.size() > 0 && !bus.stallD) void'(q.pop_front());
      if (accepted) begin
        e.pc = bus.in_pc; e.ins = bus.in_instr; e.flt = bus.in_fault;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    logic        hold;
    logic        acc;

    // Reset with in_valid held high
    reset = 1'b1;
    drive(0, 1, 32'h0000_0abc, 32'h1234_5673, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst validD",   64'(bus.validD),   64'(1'b0));
    check("rst pcD",      64'(bus.pcD),      64'(32'h0));
    check("rst instrD",   64'(bus.instrD),   64'(NOP));
    check("rst faultD",   64'(bus.faultD),   64'(1'b0));
    check("rst illegalD", 64'(bus.illegalD), 64'(1'b0));
    check("rst in_ready", 64'(bus.in_ready), 64'(1'b1));
    check("rst countD",   64'(bus.countD),   64'(0));
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Single push, one-cycle latency, popped next edge
    add(0, 1, 32'h100, 32'h00500093, 0, 0, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h00500093, 0, 0, 1, 1);
    add_idle_empty();
    // Stall until full, third fetch held off, then drain in order
    add(0, 1, 32'h100, mk(32'h100), 0, 1, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 1, 32'h104, mk(32'h104), 0, 1, 1, 32'h100, mk(32'h100), 0, 0, 1, 1);
    add(0, 1, 32'h108, mk(32'h108), 0, 1, 1, 32'h100, mk(32'h100), 0, 0, 2, 0);
    add(0, 1, 32'h108, mk(32'h108), 0, 0, 1, 32'h100, mk(32'h100), 0, 0, 2, 0);
    add(0, 1, 32'h108, mk(32'h108), 0, 0, 1, 32'h104, mk(32'h104), 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 32'h108, mk(32'h108), 0, 0, 1, 1);
    add_idle_empty();
    // Full buffer flushed together with stall and a pending fetch
    add(0, 1, 32'h300, mk(32'h300), 0, 1, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 1, 32'h304, mk(32'h304), 0, 1, 1, 32'h300, mk(32'h300), 0, 0, 1, 1);
    add(1, 1, 32'h308, mk(32'h308), 0, 1, 1, 32'h300, mk(32'h300), 0, 0, 2, 0);
    add(0, 1, 32'h308, mk(32'h308), 0, 1, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 32'h308, mk(32'h308), 0, 0, 1, 1);
    add_idle_empty();
    // Flash held for two cycles without stall
    add(0, 1, 32'h500, mk(32'h500), 0, 1, 0, 0, NOP, 0, 0, 0, 1);
    add(1, 1, 32'h504, mk(32'h504), 0, 0, 1, 32'h500, mk(32'h500), 0, 0, 1, 0);
    add(1, 1, 32'h504, mk(32'h504), 0, 0, 0, 0, NOP, 0, 0, 0, 0);
    add_idle_empty();
    // Fault bit travels only with its own instruction
    add(0, 1, 32'h1fc, mk(32'h1fc), 0, 1, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 1, 32'h200, mk(32'h200), 1, 1, 1, 32'h1fc, mk(32'h1fc), 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 32'h1fc, mk(32'h1fc), 0, 0, 2, 0);
    add(0, 1, 32'h204, mk(32'h204), 0, 0, 1, 32'h200, mk(32'h200), 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 32'h204, mk(32'h204), 0, 0, 1, 1);
    add_idle_empty();
    // Compressed encoding check
    add(0, 1, 32'h400, 32'h00004501, 0, 1, 0, 0, NOP, 0, 0, 0, 1);
    add(0, 1, 32'h404, 32'h00000013, 0, 1, 1, 32'h400, 32'h00004501, 0, ILL_EN, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 32'h400, 32'h00004501, 0, ILL_EN, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1, 32'h404, 32'h00000013, 0, 0, 1, 1);
    add_idle_empty();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].flt, vecs[i].st);
      #3;
      check($sformatf("vec%0d validD", i),   64'(bus.validD),   64'(vecs[i].ev));
      check($sformatf("vec%0d pcD", i),      64'(bus.pcD),      64'(vecs[i].epc));
      check($sformatf("vec%0d instrD", i),   64'(bus.instrD),   64'(vecs[i].eins));
      check($sformatf("vec%0d faultD", i),   64'(bus.faultD),   64'(vecs[i].efl));
      check($sformatf("vec%0d illegalD", i), 64'(bus.illegalD), 64'(vecs[i].eil));
      check($sformatf("vec%0d countD", i),   64'(bus.countD),   64'(vecs[i].ecnt));
      check($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].erdy));
      @(posedge clk); #1;
    end

    // Reset asserted mid-operation with flash, stall and in_valid all high
    drive(0, 1, 32'h600, mk(32'h600), 0, 1);
    @(posedge clk); #1;
    drive(0, 1, 32'h604, mk(32'h604), 0, 1);
    @(posedge clk); #1;
    check("mid full countD", 64'(bus.countD), 64'(2));
    drive(1, 1, 32'h608, mk(32'h608), 1, 1);
    #1 reset = 1'b1;
    #1;
    check("midrst validD", 64'(bus.validD), 64'(1'b0));
    check("midrst countD", 64'(bus.countD), 64'(0));
    check("midrst instrD", 64'(bus.instrD), 64'(NOP));
    check("midrst pcD",    64'(bus.pcD),    64'(32'h0));
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("midrst in_ready", 64'(bus.in_ready), 64'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the queue model; fetch holds its word until accepted
    q.delete();
    hold = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_pc    = $urandom;
        bus.in_instr = $urandom;
        bus.in_fault = ($urandom_range(0, 7) == 0);
      end
      bus.flash  = ($urandom_range(0, 15) == 0);
      bus.stallD = ($urandom_range(0, 2) == 0);
      #3;
      check_model(c);
      model_edge(acc);
      hold = bus.in_valid && !acc;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
